// File: rtl/fft_peak_finder.sv
// Sweeps fft_top's positive-frequency bins after done and reports
// the strongest bin by re^2+im^2, excluding DC and the mirrored half.
module fft_peak_finder #(
    parameter int bit_width = 16,
    parameter int M = 9,
    parameter int N = 512,
    parameter int RD_LAT = 1,
    parameter logic [2*bit_width:0] THRESH = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fft_done,
    input  logic [2*bit_width-1:0] wd,
    output logic [M-1:0]           rd_adr,
    output logic                   busy,
    output logic                   peak_valid,
    output logic [M-1:0]           peak_bin,
    output logic [2*bit_width:0]   peak_mag,
    output logic                   peak_found
);

    localparam int BW = bit_width;
    localparam int MW = 2 * BW + 1;
    localparam int CW = $clog2(RD_LAT + 2);
    localparam int LAST = N / 2 - 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, PUBLISH} state_t;

    typedef struct packed {
        logic         vld;
        logic [M-1:0] adr;
    } tag_t;

    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic [M-1:0]    rd_adr_q, rd_adr_d;
    logic            busy_q, busy_d;
    logic            peak_valid_q, peak_valid_d;
    logic [M-1:0]    peak_bin_q, peak_bin_d;
    logic [MW-1:0]   peak_mag_q, peak_mag_d;
    logic            peak_found_q, peak_found_d;
    logic [MW-1:0]   max_mag_q, max_mag_d;
    logic [M-1:0]    max_bin_q, max_bin_d;
    logic [MW-1:0]   mag_q, mag_d;
    logic            mag_vld_q, mag_vld_d;
    logic [M-1:0]    mag_bin_q, mag_bin_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    tag_t            tag_q [RD_LAT];
    tag_t            tag_d [RD_LAT];

    logic signed [2*BW-1:0] re_x, im_x, re_sq, im_sq;

    always_comb begin
        state_d      = state_q;
        done_d       = fft_done;
        rd_adr_d     = rd_adr_q;
        busy_d       = busy_q;
        peak_valid_d = 1'b0;
        peak_bin_d   = peak_bin_q;
        peak_mag_d   = peak_mag_q;
        peak_found_d = peak_found_q;
        max_mag_d    = max_mag_q;
        max_bin_d    = max_bin_q;
        cnt_d        = cnt_q;

        // Tag travels with each request so the returning word knows its bin
        tag_d[0].vld = (state_q == SWEEP);
        tag_d[0].adr = rd_adr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        re_x  = {{BW{wd[2*BW-1]}}, wd[2*BW-1:BW]};
        im_x  = {{BW{wd[BW-1]}}, wd[BW-1:0]};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        mag_d     = {1'b0, re_sq} + {1'b0, im_sq};
        mag_vld_d = tag_q[RD_LAT-1].vld;
        mag_bin_d = tag_q[RD_LAT-1].adr;

        // Strict compare keeps the lowest bin on ties
        if (mag_vld_q && (mag_q > max_mag_q)) begin
            max_mag_d = mag_q;
            max_bin_d = mag_bin_q;
        end

        unique case (state_q)
            IDLE: begin
                rd_adr_d = '0;
                if (fft_done && !done_q) begin
                    state_d   = SWEEP;
                    rd_adr_d  = M'(1);
                    busy_d    = 1'b1;
                    max_mag_d = '0;
                    max_bin_d = '0;
                end
            end
            SWEEP: begin
                if (rd_adr_q == M'(LAST)) begin
                    state_d  = DRAIN;
                    rd_adr_d = '0;
                    cnt_d    = '0;
                end else begin
                    rd_adr_d = rd_adr_q + 1'b1;
                end
            end
            DRAIN: begin
                // RD_LAT read cycles plus one for the registered magnitude
                if (cnt_q == CW'(RD_LAT)) begin
                    state_d = PUBLISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PUBLISH: begin
                peak_bin_d   = max_bin_q;
                peak_mag_d   = max_mag_q;
                peak_found_d = (max_mag_q > THRESH);
                peak_valid_d = 1'b1;
                busy_d       = 1'b0;
                rd_adr_d     = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            rd_adr_q     <= '0;
            busy_q       <= 1'b0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_found_q <= 1'b0;
            max_mag_q    <= '0;
            max_bin_q    <= '0;
            mag_q        <= '0;
            mag_vld_q    <= 1'b0;
            mag_bin_q    <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            rd_adr_q     <= rd_adr_d;
            busy_q       <= busy_d;
            peak_valid_q <= peak_valid_d;
            peak_bin_q   <= peak_bin_d;
            peak_mag_q   <= peak_mag_d;
            peak_found_q <= peak_found_d;
            max_mag_q    <= max_mag_d;
            max_bin_q    <= max_bin_d;
            mag_q        <= mag_d;
            mag_vld_q    <= mag_vld_d;
            mag_bin_q    <= mag_bin_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign rd_adr     = rd_adr_q;
    assign busy       = busy_q;
    assign peak_valid = peak_valid_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign peak_found = peak_found_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Bench for fft_peak_finder: two instances (RD_LAT 1 and 3) read a
// shared spectrum memory; results are checked against a plain model.
module tb_fft_peak_finder;

    localparam int N = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fft_done = 1'b0;
    logic [31:0] wd1, wd3;
    logic [8:0]  rd_adr1, rd_adr3, peak_bin1, peak_bin3;
    logic        busy1, busy3, pv1, pv3, found1, found3;
    logic [32:0] mag1, mag3;
    logic [31:0] mem [N];
    logic [8:0]  p1;
    logic [8:0]  p3 [3];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // fft_top read-latency model for each instance
    always @(posedge clk) begin
        p1    <= rd_adr1;
        p3[0] <= rd_adr3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign wd1 = mem[p1];
    assign wd3 = mem[p3[2]];

    fft_peak_finder #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .fft_done(fft_done), .wd(wd1),
        .rd_adr(rd_adr1), .busy(busy1), .peak_valid(pv1),
        .peak_bin(peak_bin1), .peak_mag(mag1), .peak_found(found1)
    );

    fft_peak_finder #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .fft_done(fft_done), .wd(wd3),
        .rd_adr(rd_adr3), .busy(busy3), .peak_valid(pv3),
        .peak_bin(peak_bin3), .peak_mag(mag3), .peak_found(found3)
    );

    task automatic clear_mem();
        for (int b = 0; b < N; b++) mem[b] = 32'h0;
    endtask

    // Strongest bin among 1..N/2-1, first one wins on ties
    task automatic model(output int bin, output longint mag);
        longint r, i, m;
        bin = 0;
        mag = 0;
        for (int b = 1; b < N / 2; b++) begin
            r = longint'($signed(mem[b][31:16]));
            i = longint'($signed(mem[b][15:0]));
            m = r * r + i * i;
            if (m > mag) begin
                mag = m;
                bin = b;
            end
        end
    endtask

    task automatic sweep(input int tog_at, input bit rel_rst,
                         output int c1, output int n1,
                         output int c3, output int n3,
                         output bit aok, output bit busy0);
        int e1, e3;
        c1 = -1; c3 = -1; n1 = 0; n3 = 0;
        aok = 1'b1; busy0 = 1'b0; e1 = 1; e3 = 1;
        @(negedge clk);
        fft_done = 1'b1;
        if (rel_rst) reset = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) busy0 = busy1 && busy3;
            if (c == 1) fft_done = 1'b0;
            if (c == tog_at) fft_done = 1'b1;
            if (c == tog_at + 2) fft_done = 1'b0;
            if (rd_adr1 != 9'd0) begin
                if (rd_adr1 != 9'(e1)) aok = 1'b0;
                e1++;
            end
            if (rd_adr3 != 9'd0) begin
                if (rd_adr3 != 9'(e3)) aok = 1'b0;
                e3++;
            end
            if (pv1) begin n1++; c1 = c; end
            if (pv3) begin n3++; c3 = c; end
        end
        if (e1 != N / 2 || e3 != N / 2) aok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fft_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (rd_adr1 !== 9'd0) begin fails++; $display("FAIL reset_rd_adr: got %0d want 0", rd_adr1); end
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy1); end
        tests++; if (pv1 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", pv1); end
        tests++; if (peak_bin1 !== 9'd0) begin fails++; $display("FAIL reset_bin: got %0d want 0", peak_bin1); end
        tests++; if (mag1 !== 33'd0) begin fails++; $display("FAIL reset_mag: got %0h want 0", mag1); end
        tests++; if (found1 !== 1'b0) begin fails++; $display("FAIL reset_found: got %b want 0", found1); end
        tests++; if (busy3 !== 1'b0 || rd_adr3 !== 9'd0) begin fails++; $display("FAIL reset_lat3: busy %b adr %0d want 0 0", busy3, rd_adr3); end
    endtask

    task automatic test_single_tone();
        int c1, n1, c3, n3;
        bit aok, b0;
        clear_mem();
        mem[20] = 32'h4000_0000;
        sweep(-1, 1'b0, c1, n1, c3, n3, aok, b0);
        tests++; if (!aok) begin fails++; $display("FAIL tone_addr_seq: got bad order want 1..255"); end
        tests++; if (!b0) begin fails++; $display("FAIL tone_busy: got 0 want 1 after trigger"); end
        tests++; if (c1 != 258 || n1 != 1) begin fails++; $display("FAIL tone_lat1: got cyc %0d cnt %0d want 258 1", c1, n1); end
        tests++; if (c3 != 260 || n3 != 1) begin fails++; $display("FAIL tone_lat3: got cyc %0d cnt %0d want 260 1", c3, n3); end
        tests++; if (peak_bin1 !== 9'd20) begin fails++; $display("FAIL tone_bin: got %0d want 20", peak_bin1); end
        tests++; if (mag1 !== 33'h010000000) begin fails++; $display("FAIL tone_mag: got %0h want 10000000", mag1); end
        tests++; if (found1 !== 1'b1) begin fails++; $display("FAIL tone_found: got %b want 1", found1); end
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL tone_busy_end: got %b want 0", busy1); end
        tests++; if (peak_bin3 !== 9'd20 || mag3 !== 33'h010000000) begin fails++; $display("FAIL tone_lat3_res: got %0d %0h want 20 10000000", peak_bin3, mag3); end
    endtask

    task automatic test_tie_excl();
        int c1, n1, c3, n3;
        bit aok, b0;
        clear_mem();
        mem[10]  = 32'h1000_1000;
        mem[30]  = 32'h1000_1000;
        mem[0]   = 32'h7FFF_7FFF;
        mem[300] = 32'h7FFF_7FFF;
        sweep(-1, 1'b0, c1, n1, c3, n3, aok, b0);
        tests++; if (!aok) begin fails++; $display("FAIL tie_addr_seq: got bad order want 1..255"); end
        tests++; if (peak_bin1 !== 9'd10) begin fails++; $display("FAIL tie_bin: got %0d want 10", peak_bin1); end
        tests++; if (mag1 !== 33'h002000000) begin fails++; $display("FAIL tie_mag: got %0h want 2000000", mag1); end
        tests++; if (peak_bin3 !== 9'd10) begin fails++; $display("FAIL tie_bin3: got %0d want 10", peak_bin3); end
    endtask

    task automatic test_extreme();
        int c1, n1, c3, n3;
        bit aok, b0;
        clear_mem();
        mem[5] = 32'h8000_8000;
        mem[6] = 32'h7FFF_7FFF;
        sweep(-1, 1'b0, c1, n1, c3, n3, aok, b0);
        tests++; if (peak_bin1 !== 9'd5) begin fails++; $display("FAIL ext_bin: got %0d want 5", peak_bin1); end
        tests++; if (mag1 !== 33'h080000000) begin fails++; $display("FAIL ext_mag: got %0h want 80000000", mag1); end
        tests++; if (mag3 !== 33'h080000000) begin fails++; $display("FAIL ext_mag3: got %0h want 80000000", mag3); end
    endtask

    task automatic test_zero();
        int c1, n1, c3, n3;
        bit aok, b0;
        clear_mem();
        sweep(-1, 1'b0, c1, n1, c3, n3, aok, b0);
        tests++; if (c1 != 258 || n1 != 1) begin fails++; $display("FAIL zero_lat1: got %0d %0d want 258 1", c1, n1); end
        tests++; if (c3 != 260 || n3 != 1) begin fails++; $display("FAIL zero_lat3: got %0d %0d want 260 1", c3, n3); end
        tests++; if (peak_bin1 !== 9'd0 || mag1 !== 33'd0) begin fails++; $display("FAIL zero_res1: got %0d %0h want 0 0", peak_bin1, mag1); end
        tests++; if (found1 !== 1'b0) begin fails++; $display("FAIL zero_found1: got %b want 0", found1); end
        tests++; if (peak_bin3 !== 9'd0 || mag3 !== 33'd0 || found3 !== 1'b0) begin fails++; $display("FAIL zero_res3: got %0d %0h %b want 0 0 0", peak_bin3, mag3, found3); end
    endtask

    task automatic test_random();
        int c1, n1, c3, n3, eb;
        longint em;
        bit aok, b0;
        logic [15:0] re, im;
        for (int it = 0; it < 6; it++) begin
            for (int b = 0; b < N; b++) begin
                if (it % 2 == 0) begin
                    mem[b] = $urandom;
                end else begin
                    re = 16'($urandom_range(0, 2)) - 16'd1;
                    im = 16'($urandom_range(0, 2)) - 16'd1;
                    mem[b] = {re, im};
                end
            end
            model(eb, em);
            sweep(-1, 1'b0, c1, n1, c3, n3, aok, b0);
            tests++; if (peak_bin1 !== 9'(eb) || mag1 !== 33'(em)) begin fails++; $display("FAIL rand_res1[%0d]: got %0d %0h want %0d %0h", it, peak_bin1, mag1, eb, em); end
            tests++; if (peak_bin3 !== 9'(eb) || mag3 !== 33'(em)) begin fails++; $display("FAIL rand_res3[%0d]: got %0d %0h want %0d %0h", it, peak_bin3, mag3, eb, em); end
            tests++; if (found1 !== (em > 0)) begin fails++; $display("FAIL rand_found[%0d]: got %b want %b", it, found1, em > 0); end
            tests++; if (n1 != 1 || n3 != 1) begin fails++; $display("FAIL rand_pulses[%0d]: got %0d %0d want 1 1", it, n1, n3); end
        end
    endtask

    task automatic test_retrigger();
        int c1, n1, c3, n3, eb;
        longint em;
        bit aok, b0;
        clear_mem();
        mem[77] = 32'h0123_FF00;
        model(eb, em);
        sweep(50, 1'b0, c1, n1, c3, n3, aok, b0);
        tests++; if (c1 != 258 || n1 != 1) begin fails++; $display("FAIL retrig_pulse: got %0d %0d want 258 1", c1, n1); end
        tests++; if (peak_bin1 !== 9'(eb) || mag1 !== 33'(em)) begin fails++; $display("FAIL retrig_res: got %0d %0h want %0d %0h", peak_bin1, mag1, eb, em); end
    endtask

    task automatic test_reset_mid();
        int c1, n1, c3, n3, np;
        bit aok, b0;
        clear_mem();
        mem[40] = 32'h2000_0000;
        np = 0;
        @(negedge clk);
        fft_done = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 1) fft_done = 1'b0;
            if (c == 100) reset = 1'b1;
            if (c == 101) begin
                tests++; if (busy1 !== 1'b0 || rd_adr1 !== 9'd0) begin fails++; $display("FAIL midrst_idle: got busy %b adr %0d want 0 0", busy1, rd_adr1); end
                tests++; if (mag1 !== 33'd0 || peak_bin1 !== 9'd0) begin fails++; $display("FAIL midrst_clear: got %0d %0h want 0 0", peak_bin1, mag1); end
                reset = 1'b0;
            end
            if (pv1 || pv3) np++;
        end
        tests++; if (np != 0) begin fails++; $display("FAIL midrst_novalid: got %0d pulses want 0", np); end
        sweep(-1, 1'b0, c1, n1, c3, n3, aok, b0);
        tests++; if (c1 != 258 || peak_bin1 !== 9'd40) begin fails++; $display("FAIL midrst_resume: got %0d bin %0d want 258 40", c1, peak_bin1); end
        tests++; if (mag1 !== 33'h004000000) begin fails++; $display("FAIL midrst_mag: got %0h want 4000000", mag1); end
    endtask

    task automatic test_done_in_reset();
        int c1, n1, c3, n3;
        bit aok, b0;
        clear_mem();
        mem[200] = 32'h0000_7000;
        reset = 1'b1;
        fft_done = 1'b1;
        repeat (3) @(negedge clk);
        sweep(-1, 1'b1, c1, n1, c3, n3, aok, b0);
        tests++; if (c1 != 258 || n1 != 1) begin fails++; $display("FAIL rstdone_pulse: got %0d %0d want 258 1", c1, n1); end
        tests++; if (peak_bin1 !== 9'd200 || mag1 !== 33'h031000000) begin fails++; $display("FAIL rstdone_res: got %0d %0h want 200 31000000", peak_bin1, mag1); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_single_tone();
        test_tie_excl();
        test_extreme();
        test_zero();
        test_random();
        test_retrigger();
        test_reset_mid();
        test_done_in_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
